// File: rtl/audio_pkg.sv
// audio_pkg: constants and types shared by
// the sample sources and the I2S transmitter.
package audio_pkg;

  localparam int AUDIO_DATA_W = 16;

  // word-select level that marks the left slot
  localparam logic LRCK_LEFT = 1'b0;

  typedef struct packed {
    logic [AUDIO_DATA_W-1:0] left;
    logic [AUDIO_DATA_W-1:0] right;
  } sample_pair_t;

endpackage

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: divides clk down to BCLK and
// strobes the clk in which BCLK falls.
module i2s_bclk_gen #(
  parameter int BCLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bclk,
  output logic fall
);

  localparam int CW = $clog2(BCLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(BCLK_DIV - 1);

  logic [CW-1:0] div_cnt;
  logic          tick;

  assign tick = (div_cnt == LAST);
  assign fall = en && !rst && tick && bclk;

  // half-period divider; held idle-low while disabled
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: Philips-I2S transmitter with
// a one-pair holding register and underrun flag.
module i2s_tx_serializer
  import audio_pkg::*;
#(
  parameter int DATA_W   = AUDIO_DATA_W,
  parameter int SLOT_W   = 16,
  parameter int BCLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              i2s_bclk,
  output logic              i2s_lrck,
  output logic              i2s_sdata,
  output logic              underrun
);

  localparam int FW = 2 * SLOT_W;
  localparam int CW = $clog2(FW);
  localparam logic [CW-1:0] LAST = CW'(FW - 1);
  localparam logic [CW-1:0] HALF = CW'(SLOT_W);

  logic              fall;
  logic              accept;
  logic              load;
  logic              hold_full;
  logic [DATA_W-1:0] hold_l;
  logic [DATA_W-1:0] hold_r;
  logic [FW-1:0]     frame;
  logic [FW-1:0]     shreg;
  logic [CW-1:0]     bit_cnt;
  logic [CW-1:0]     nxt_cnt;

  i2s_bclk_gen #(
    .BCLK_DIV(BCLK_DIV)
  ) u_bclk (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bclk(i2s_bclk),
    .fall(fall)
  );

  assign s_ready = !hold_full && !rst;
  assign accept  = s_valid && s_ready;
  assign nxt_cnt = (bit_cnt == LAST) ? '0 : bit_cnt + CW'(1);
  assign load    = fall && (nxt_cnt == '0);

  // frame image: MSB of each slot first, zero pad after LSB
  always_comb begin
    frame = '0;
    frame[FW-1 -: DATA_W]     = hold_l;
    frame[SLOT_W-1 -: DATA_W] = hold_r;
  end

  // holding flag: filled by handshake, drained at frame load
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_full <= 1'b1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  // holding data: only meaningful while hold_full is set
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_l <= s_left;
      hold_r <= s_right;
    end
  end

  // serializer: shifts on each BCLK fall, last bit of a
  // frame goes out in slot 0 of the next (1-bit delay)
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      bit_cnt   <= LAST;
      shreg     <= '0;
      i2s_lrck  <= ~LRCK_LEFT;
      i2s_sdata <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (fall) begin
        bit_cnt   <= nxt_cnt;
        i2s_lrck  <= (nxt_cnt >= HALF) ? ~LRCK_LEFT : LRCK_LEFT;
        i2s_sdata <= shreg[FW-1];
        if (load) begin
          shreg    <= hold_full ? frame : '0;
          underrun <= !hold_full;
        end else begin
          shreg <= {shreg[FW-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb_i2s_tx_serializer: time-based model of the
// I2S link plus directed hand-checked vectors.
module tb_i2s_tx_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [15:0] l0 = '0, r0 = '0, l1 = '0, r1 = '0;
  logic        rdy0, bclk0, lrck0, sd0, und0;
  logic        rdy1, bclk1, lrck1, sd1, und1;

  int checks = 0;
  int passed = 0;
  bit go = 1'b0;
  bit rel = 1'b0;
  bit u1_done = 1'b0;

  always #5 clk = ~clk;

  i2s_tx_serializer u0 (
    .clk(clk), .rst(rst), .en(en),
    .s_valid(v0), .s_ready(rdy0),
    .s_left(l0), .s_right(r0),
    .i2s_bclk(bclk0), .i2s_lrck(lrck0),
    .i2s_sdata(sd0), .underrun(und0)
  );

  i2s_tx_serializer #(.SLOT_W(24)) u1 (
    .clk(clk), .rst(rst), .en(en),
    .s_valid(v1), .s_ready(rdy1),
    .s_left(l1), .s_right(r1),
    .i2s_bclk(bclk1), .i2s_lrck(lrck1),
    .i2s_sdata(sd1), .underrun(und1)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
  endtask

  task automatic tmo(input string nm);
    checks++;
    $display("FAIL timeout %s: event not seen, required within bound", nm);
  endtask

  // ---------------- model ----------------
  // n = enabled clk edges since reset/enable; everything
  // else follows from n and the frames that were loaded.
  int          n   [2];
  bit          hf  [2];
  bit [15:0]   hl  [2];
  bit [15:0]   hr  [2];
  bit          cur [2][48];
  bit          pl  [2];
  bit          mu  [2];

  function automatic bit fbit(input bit [15:0] l, input bit [15:0] r,
                              input int b, input int s);
    int p;
    bit [15:0] w;
    p = (b < s) ? b : b - s;
    w = (b < s) ? l : r;
    return (p < 16) ? w[15-p] : 1'b0;
  endfunction

  task automatic mstep(input int i, input int s, input logic v,
                       input logic [15:0] l, input logic [15:0] r);
    bit acc;
    if (rst) begin
      n[i] = 0; hf[i] = 0; mu[i] = 0; pl[i] = 0;
      for (int b = 0; b < 48; b++) cur[i][b] = 1'b0;
    end else begin
      acc = v && !hf[i];
      mu[i] = 0;
      if (!en) begin
        n[i] = 0; pl[i] = 0;
        for (int b = 0; b < 48; b++) cur[i][b] = 1'b0;
      end else begin
        n[i]++;
        if (n[i] % 8 == 0 && ((n[i] / 8 - 1) % (2 * s)) == 0) begin
          pl[i] = cur[i][2*s-1];
          mu[i] = !hf[i];
          for (int b = 0; b < 48; b++)
            cur[i][b] = hf[i] ? fbit(hl[i], hr[i], b, s) : 1'b0;
          hf[i] = 0;
        end
      end
      if (acc) begin
        hl[i] = l; hr[i] = r; hf[i] = 1;
      end
    end
  endtask

  task automatic cmp(input int i, input int s, input logic [4:0] act);
    int m, k;
    logic [4:0] e;
    m = n[i] / 8;
    e[4] = ((n[i] / 4) % 2) == 1;
    if (m == 0) begin
      e[3] = 1'b1; e[2] = 1'b0;
    end else begin
      k = (m - 1) % (2 * s);
      e[3] = (k >= s);
      e[2] = (k == 0) ? pl[i] : cur[i][k-1];
    end
    e[1] = mu[i];
    e[0] = !hf[i] && !rst;
    if (i == 0) chk("u0 {bclk,lrck,sdata,underrun,ready}", act, e);
    else        chk("u1 {bclk,lrck,sdata,underrun,ready}", act, e);
  endtask

  initial forever begin
    @(posedge clk);
    mstep(0, 16, v0, l0, r0);
    mstep(1, 24, v1, l1, r1);
    if (rst) go = 1'b1;
  end

  initial forever begin
    @(negedge clk);
    #1;
    if (go) begin
      cmp(0, 16, {bclk0, lrck0, sd0, und0, rdy0});
      cmp(1, 24, {bclk1, lrck1, sd1, und1, rdy1});
    end
  end

  // ---------------- helpers ----------------
  task automatic smp(input int i, output logic b, output logic l,
                     output logic d, output logic u);
    b = (i == 0) ? bclk0 : bclk1;
    l = (i == 0) ? lrck0 : lrck1;
    d = (i == 0) ? sd0 : sd1;
    u = (i == 0) ? und0 : und1;
  endtask

  task automatic wait_fs(input int i);
    logic b, l, d, u, lp;
    int t;
    bit hit;
    t = 0; hit = 0;
    smp(i, b, lp, d, u);
    while (!hit && t < 3000) begin
      @(negedge clk); t++;
      smp(i, b, l, d, u);
      hit = lp && !l;
      lp = l;
    end
    if (!hit) tmo("frame start");
  endtask

  task automatic collect(input int i, input int nb, output logic [63:0] v);
    logic b, l, d, u, pb;
    int t, c;
    t = 0; c = 0; v = '0;
    smp(i, pb, l, d, u);
    while (c < nb && t < 3000) begin
      @(negedge clk); t++;
      smp(i, b, l, d, u);
      if (b && !pb) begin
        v = {v[62:0], d};
        c++;
      end
      pb = b;
    end
    if (c < nb) tmo("collect bits");
  endtask

  task automatic count_falls(input int i, input int nf);
    logic b, l, d, u, pb;
    int t, c;
    t = 0; c = 0;
    smp(i, pb, l, d, u);
    while (c < nf && t < 3000) begin
      @(negedge clk); t++;
      smp(i, b, l, d, u);
      if (pb && !b) c++;
      pb = b;
    end
    if (c < nf) tmo("bclk falls");
  endtask

  task automatic rises_to_fs(input int i, output int c);
    logic b, l, d, u, pb, lp;
    int t;
    bit hit;
    t = 0; c = 0; hit = 0;
    smp(i, pb, lp, d, u);
    while (!hit && t < 3000) begin
      @(negedge clk); t++;
      smp(i, b, l, d, u);
      if (b && !pb) c++;
      hit = lp && !l;
      pb = b; lp = l;
    end
    if (!hit) tmo("lrck period");
  endtask

  // called at a negedge; returns one negedge after transfer
  task automatic send0(input logic [15:0] l, input logic [15:0] r);
    int t;
    t = 0;
    v0 = 1'b1; l0 = l; r0 = r;
    while (!rdy0 && t < 3000) begin
      @(negedge clk); t++;
    end
    @(negedge clk);
    v0 = 1'b0;
    if (t >= 3000) tmo("send handshake");
  endtask

  // ---------------- u1: 24-bit slots ----------------
  initial begin
    logic [63:0] v;
    int c;
    wait (rel);
    wait_fs(1);
    wait_fs(1);
    collect(1, 25, v);
    chk("u1 left slot 16 ones + 8 pad", v[23:0], 24'hFFFF00);
    wait_fs(1);
    rises_to_fs(1, c);
    chk("u1 bclk per lrck period", c, 48);
    u1_done = 1'b1;
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] v;
    int fu, fl, uc, t, cap;
    int cap_t [5];
    bit took, edge_ok;
    logic lp;

    // reset
    rst = 1'b1; en = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst bclk", bclk0, 0);
    chk("rst lrck", lrck0, 1);
    chk("rst sdata", sd0, 0);
    chk("rst s_ready", rdy0, 0);
    rst = 1'b0;
    rel = 1'b1;

    // first fall at clk 8; pair accepted in that same clk
    fu = 0; fl = 0; uc = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 8) begin
        v0 = 1'b1; l0 = 16'h8001; r0 = 16'h7FFE;
        v1 = 1'b1; l1 = 16'hFFFF; r1 = 16'h1234;
      end
      if (i == 9) begin
        v0 = 1'b0; v1 = 1'b0;
      end
      @(negedge clk);
      if (und0) begin
        uc++;
        if (fu == 0) fu = i;
      end
      if (!lrck0 && fl == 0) fl = i;
    end
    chk("first underrun clk", fu, 8);
    chk("underrun pulses after reset", uc, 1);
    chk("first lrck low clk", fl, 8);

    // frame 2 carries the pair, after the delay bit
    wait_fs(0);
    collect(0, 33, v);
    chk("frame2 bits", v[32:0], {1'b0, 16'h8001, 16'h7FFE});

    // backpressure: s_valid held, counter pattern
    cap = 0; t = 0; uc = 0;
    v0 = 1'b1; l0 = 16'h1000; r0 = 16'hA000;
    while (cap < 5 && t < 3000) begin
      took = rdy0;
      @(negedge clk); t++;
      if (und0) uc++;
      if (took) begin
        cap_t[cap] = t;
        cap++;
        l0 = l0 + 16'd1;
        r0 = r0 + 16'd1;
      end
    end
    v0 = 1'b0;
    if (cap < 5) tmo("backpressure captures");
    chk("capture spacing 1-2", cap_t[2] - cap_t[1], 256);
    chk("capture spacing 1-4", cap_t[4] - cap_t[1], 768);
    chk("underruns under backpressure", uc, 0);

    // underrun: stop offering for a frame
    uc = 0; t = 0; edge_ok = 0;
    lp = lrck0;
    while (uc == 0 && t < 1000) begin
      @(negedge clk); t++;
      if (und0) begin
        uc++;
        edge_ok = lp && !lrck0;
      end
      lp = lrck0;
    end
    if (uc == 0) tmo("underrun pulse");
    chk("underrun on lrck fall", edge_ok, 1);
    @(negedge clk);
    chk("underrun one clk wide", und0, 0);
    send0(16'h1357, 16'h2468);
    wait_fs(0);
    chk("resume without underrun", und0, 0);
    collect(0, 33, v);
    chk("resume frame bits", v[32:0], {1'b0, 16'h1357, 16'h2468});

    wait (u1_done);

    // reset at bit_cnt 7 with a pair pending
    wait_fs(0);
    send0(16'hC0DE, 16'h0BAD);
    count_falls(0, 7);
    chk("lrck at bit 7", lrck0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid rst bclk", bclk0, 0);
    chk("mid rst lrck", lrck0, 1);
    chk("mid rst sdata", sd0, 0);
    rst = 1'b0;
    #1;
    chk("rst empties holding", rdy0, 1);
    fu = 0; uc = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (und0) begin
        uc++;
        if (fu == 0) fu = i;
      end
    end
    chk("underrun clk after mid rst", fu, 8);

    // disable at bit_cnt 20 with a pair pending
    wait_fs(0);
    send0(16'hBEEF, 16'h5A5A);
    count_falls(0, 20);
    chk("lrck at bit 20", lrck0, 1);
    en = 1'b0;
    @(negedge clk);
    chk("en off bclk", bclk0, 0);
    chk("en off lrck", lrck0, 1);
    chk("en off sdata", sd0, 0);
    chk("en off holding kept", rdy0, 0);
    repeat (5) @(negedge clk);
    en = 1'b1;
    fl = 0; uc = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (und0) uc++;
      if (!lrck0 && fl == 0) fl = i;
    end
    chk("re-enable no underrun", uc, 0);
    chk("re-enable first fall clk", fl, 8);
    collect(0, 33, v);
    chk("re-enable frame bits", v[32:0], {1'b0, 16'hBEEF, 16'h5A5A});

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
- Consumes stereo 16-bit two's-complement PCM sample pairs, for example from the on-chip sine/tone sample sources.
- Serialises them onto a Philips-I2S link toward the board audio DAC. The link uses a 1-BCLK data delay and MSB first.
- Generates BCLK and LRCK from the system clock, buffers one pending sample pair, and flags underruns.
- Sits between the sample-source blocks and the DAC pins.

Parameters:
- DATA_W, 16: sample width per channel.
- SLOT_W, 16: BCLK cycles per channel slot. Must satisfy SLOT_W >= DATA_W. Bits after the sample LSB are padded with 0.
- BCLK_DIV, 4: clk cycles per BCLK half-period. Must be >= 2.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  link enable.
- s_valid  in  1  sample pair offered.
- s_ready  out  1  holding register can accept.
- s_left  in  DATA_W  left sample, two's complement.
- s_right  in  DATA_W  right sample, two's complement.
- i2s_bclk  out  1  bit clock.
- i2s_lrck  out  1  word select; 0 = left, 1 = right.
- i2s_sdata  out  1  serial data.
- underrun  out  1  one-clk pulse when a frame starts with no sample pair available.

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - bclk=0, lrck=1, sdata=0, underrun=0, s_ready=0 (while rst is high).
  - Holding register empty; outgoing frame shift data all zeros.
  - div_cnt=0; bit_cnt=2*SLOT_W-1.
- Reset mid-frame aborts the frame immediately. No partial-frame completion.
- Clock generation, while en=1:
  - div_cnt counts 0..BCLK_DIV-1.
  - At div_cnt==BCLK_DIV-1, bclk toggles.
  - A toggle with bclk==1 is a "fall event".
  - First rise is BCLK_DIV clks after reset release; first fall is at 2*BCLK_DIV.
- On each fall event:
  - bit_cnt increments modulo 2*SLOT_W.
  - lrck = (new bit_cnt >= SLOT_W).
  - sdata updates in the same clk as the bclk fall.
  - All outputs are registered.
- Frame bits F[0..2*SLOT_W-1]:
  - F[0..SLOT_W-1] = left sample MSB first, then zero pad.
  - F[SLOT_W..] = right sample, same layout.
- Waveform after the fall event with new bit_cnt=k:
  - k>=1: sdata = F[k-1] of the current frame.
  - k=0: sdata = F[2*SLOT_W-1] of the previous frame (I2S 1-bit delay).
- Load: at the fall event where bit_cnt wraps to 0, the current frame is loaded.
  - Holding register full: frame = holding contents; holding becomes empty.
  - Holding register empty: frame = all zeros; underrun=1 for exactly that clk.
- Handshake:
  - s_ready = holding empty and not rst.
  - Transfer occurs when s_valid && s_ready on a clk edge; the pair is captured into the holding register.
  - Load decision uses the holding state before the edge. Accept and underrun-load in the same clk gives: underrun pulse, zero frame, holding becomes full.
  - s_left/s_right only need to be stable in the transfer cycle.
- Enable:
  - en=0 (sampled each clk): bclk=0, lrck=1, sdata=0, div_cnt=0, bit_cnt=2*SLOT_W-1.
  - Holding register is retained; handshake still operates.
  - Re-enable behaves as after reset, except holding contents are kept.
- Timing figures:
  - Frame period = 4*BCLK_DIV*SLOT_W clk, which is 256 clk at default parameters.
  - Latency from accepted pair to MSB on sdata is at most 2 frames.

Decomposition:
- audio_pkg:
  - DATA_W default constant.
  - Stereo sample-pair typedef {left, right}.
  - I2S polarity constant (LRCK_LEFT=0).
- Sub-module i2s_bclk_gen:
  - Contains div_cnt, the bclk register, and the fall-event strobe.
  - Handles the en/rst clear.
  - Instantiated once.

Test Plan:
1. Reset: hold rst 5 clk, release, en=1, s_valid=0.
   - During rst: bclk=0, lrck=1, sdata=0, s_ready=0.
   - At first fall (clk 8 after release): lrck=0 and underrun pulses once.
2. Single frame, defaults: L=16'h8001, R=16'h7FFE, offered before the first fall.
   - Frame 1 is zeros with underrun.
   - On frame 2, sdata samples on BCLK rise read 0, 1000000000000001, 0111111111111110 (first bit is the delay bit).
   - lrck toggles every 16 BCLK.
3. Backpressure: s_valid held high with an incrementing counter pattern.
   - s_ready deasserts after each capture and reasserts at each frame load.
   - Exactly one pair is consumed per 256 clk; no drops or repeats.
   - No underrun after the first frame.
4. Underrun: stop s_valid for one frame.
   - Zero frame is sent; underrun pulses once, 1 clk wide, at the lrck 1->0 fall.
   - Transmission resumes with the next pair.
5. SLOT_W=24, DATA_W=16: sample L=16'hFFFF.
   - Left slot carries 16 ones, then 8 zeros.
   - lrck period is 48 BCLK.
6. Mid-frame rst at bit_cnt=7 and, separately, en=0 at bit_cnt=20.
   - Outputs reach their idle values the next clk.
   - rst case: holding is emptied.
   - en case: holding is retained and that pair is sent in the first frame after re-enable, without underrun.
